logos_multi_dispatch: RTL and testbench
=======================================

// Module: logos_multi_dispatch
// PURPOSE
//   Parametrised command dispatcher between one command source and NUM_ENG ntt_engine instances.
//   Buffers commands in a FIFO and routes each to engine (slot % NUM_ENG).
//   Latches a per-engine modulus context (q, mu, n_inv), selected per command from an N_CTX-entry table.
//   Adds SYNC barrier and HALT-drain semantics; sits inside the core between command_processor and the engines.
// PARAMETERS
//   NUM_ENG     4   engine channels; power of 2, >=2
//   FIFO_DEPTH  8   command FIFO entries; power of 2
//   N_CTX       4   context table entries; power of 2, >=2
//   SLOT_W      4   slot field width; >= log2(NUM_ENG)
//   ADDR_W      48  DMA address width
// PORTS
//   clk               in   1                  clock
//   rst               in   1                  synchronous active-high reset
//   in_valid          in   1                  command offered
//   in_ready          out  1                  command accepted when in_valid & in_ready
//   in_opcode         in   8                  opcode; 8'hFE=SYNC, 8'hFF=HALT, others forwarded
//   in_slot           in   SLOT_W             slot; low log2(NUM_ENG) bits select engine
//   in_dma_addr       in   ADDR_W             DMA address, forwarded unchanged
//   in_ctx            in   log2(N_CTX)        context table index
//   ctx_we            in   1                  context table write strobe
//   ctx_waddr         in   log2(N_CTX)        write index
//   ctx_wq/ctx_wmu/ctx_wninv  in  64 each     context write data
//   eng_ready         in   NUM_ENG            per-engine ready
//   eng_cmd_valid     out  NUM_ENG            one-cycle issue pulse per engine
//   eng_cmd_opcode    out  8*NUM_ENG          flattened; engine e at [8e+:8]
//   eng_cmd_slot      out  SLOT_W*NUM_ENG     flattened
//   eng_cmd_dma_addr  out  ADDR_W*NUM_ENG     flattened
//   eng_q/eng_mu/eng_n_inv  out  64*NUM_ENG   latched context per engine
//   halted            out  1                  sticky after HALT drain
//   dbg_state         out  2                  0=RUN 1=BARRIER 2=DRAIN 3=HALTED
//   dbg_fifo_count    out  log2(FIFO_DEPTH)+1 FIFO occupancy
// BEHAVIOUR
//   Reset: all registered outputs 0, FIFO empty, context table 0, state RUN.
//     in_ready=0 while rst=1 and 1 on the first cycle after reset.
//   in_ready = (state==RUN) & !fifo_full & !halt_accepted (combinational).
//     Full FIFO: in_ready=0; accept+pop in the same cycle is legal only when not full.
//   Latency: accepted at edge t, earliest eng_cmd_valid high in cycle t+1 (empty FIFO).
//     Throughput one issue/cycle total.
//   Dispatch is strictly in order from the FIFO head. Target engine e = head.slot % NUM_ENG.
//     Issue when eng_ready[e]=1 and e was not issued in the previous cycle (1-cycle guard).
//     Otherwise the head blocks; head-of-line blocking is intended.
//   Issue: eng_cmd_valid[e] high for exactly one cycle.
//     opcode/slot/dma_addr and ctx_table[head.ctx] are registered into engine e's lanes on the same edge.
//     Lanes hold until the next issue to e.
//   Context table: write occurs at the edge.
//     A dispatch reading the index written in the same cycle gets the OLD value.
//   SYNC at head: pop without issue; RUN->BARRIER. BARRIER->RUN when &eng_ready and no guard active.
//     in_ready=0 in BARRIER.
//   HALT accepted: in_ready=0 permanently. When HALT reaches head: pop, state DRAIN.
//     DRAIN->HALTED when &eng_ready (the FIFO is already empty at that point).
//     HALTED: halted=1, no issue, sticky until rst.
//   Reset mid-operation: FIFO flushed, pending pulses dropped, all lanes cleared next cycle.
//     Engines are reset by the same rst.
// STRUCTURE
//   logos_pkg: OP_SYNC, OP_HALT, dispatch-state enum, cmd_t {opcode, slot, dma_addr, ctx}, ctx_t {q, mu, n_inv}.
//   Sub-module logos_cmd_fifo: synchronous FIFO of cmd_t, DEPTH param, full/empty/count outputs.
//   Top: dispatch FSM, guard register, context table, per-engine lane registers (generate loop).
// TESTING
//   Reset, then 4 cmds slots 0..3 on back-to-back cycles, engines ready -> eng_cmd_valid = 0001, 0010, 0100, 1000 in cycles 1..4.
//   Two cmds to slot 1, eng_ready[1] held 0 for 5 cycles -> no issue; first issues cycle after ready; second blocked by guard one cycle.
//   ctx_we idx2 q=0xFFFFFFFF00000001 plus cmd ctx=2 same cycle -> eng_q lane shows old value; repeat next cycle -> new value.
//   Fill FIFO with 8 cmds to a busy engine -> in_ready=0, dbg_fifo_count=8; a 9th offer is not accepted.
//   cmd slot0, SYNC, cmd slot1, engine0 ready delayed 10 cycles -> dbg_state=1 during wait; slot1 issues only after &eng_ready.
//   HALT after 2 cmds -> in_ready drops after accept; halted=1 after both issue and all ready; rst mid-DRAIN -> halted=0, FIFO empty.

Source files
------------

// File: rtl/logos_pkg.sv
// Shared types and constants for the multi-engine command dispatcher.
// Command field widths live here because cmd_t is shared by the FIFO and the top.
package logos_pkg;

    localparam int CMD_SLOT_W = 4;
    localparam int CMD_ADDR_W = 48;
    localparam int CMD_CTX_W  = 2;

    localparam logic [7:0] OP_SYNC = 8'hFE;
    localparam logic [7:0] OP_HALT = 8'hFF;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BARRIER = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_HALTED  = 2'd3
    } disp_state_e;

    typedef struct packed {
        logic [7:0]            opcode;
        logic [CMD_SLOT_W-1:0] slot;
        logic [CMD_ADDR_W-1:0] dma_addr;
        logic [CMD_CTX_W-1:0]  ctx;
    } cmd_t;

    typedef struct packed {
        logic [63:0] q;
        logic [63:0] mu;
        logic [63:0] n_inv;
    } ctx_t;

endpackage

// File: rtl/logos_multi_dispatch_if.sv
// Command, context-write, engine-lane and debug signals of the dispatcher.
// The slave modport is the dispatcher's view; master is the surrounding core.
interface logos_multi_dispatch_if #(
    parameter int NUM_ENG    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int N_CTX      = 4,
    parameter int SLOT_W     = 4,
    parameter int ADDR_W     = 48
);
    localparam int CTX_W = $clog2(N_CTX);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                      in_valid;
    logic                      in_ready;
    logic [7:0]                in_opcode;
    logic [SLOT_W-1:0]         in_slot;
    logic [ADDR_W-1:0]         in_dma_addr;
    logic [CTX_W-1:0]          in_ctx;
    logic                      ctx_we;
    logic [CTX_W-1:0]          ctx_waddr;
    logic [63:0]               ctx_wq;
    logic [63:0]               ctx_wmu;
    logic [63:0]               ctx_wninv;
    logic [NUM_ENG-1:0]        eng_ready;
    logic [NUM_ENG-1:0]        eng_cmd_valid;
    logic [8*NUM_ENG-1:0]      eng_cmd_opcode;
    logic [SLOT_W*NUM_ENG-1:0] eng_cmd_slot;
    logic [ADDR_W*NUM_ENG-1:0] eng_cmd_dma_addr;
    logic [64*NUM_ENG-1:0]     eng_q;
    logic [64*NUM_ENG-1:0]     eng_mu;
    logic [64*NUM_ENG-1:0]     eng_n_inv;
    logic                      halted;
    logic [1:0]                dbg_state;
    logic [CNT_W-1:0]          dbg_fifo_count;

    modport slave (
        input  in_valid, in_opcode, in_slot, in_dma_addr, in_ctx,
        input  ctx_we, ctx_waddr, ctx_wq, ctx_wmu, ctx_wninv, eng_ready,
        output in_ready, eng_cmd_valid, eng_cmd_opcode, eng_cmd_slot, eng_cmd_dma_addr,
        output eng_q, eng_mu, eng_n_inv, halted, dbg_state, dbg_fifo_count
    );

    modport master (
        output in_valid, in_opcode, in_slot, in_dma_addr, in_ctx,
        output ctx_we, ctx_waddr, ctx_wq, ctx_wmu, ctx_wninv, eng_ready,
        input  in_ready, eng_cmd_valid, eng_cmd_opcode, eng_cmd_slot, eng_cmd_dma_addr,
        input  eng_q, eng_mu, eng_n_inv, halted, dbg_state, dbg_fifo_count
    );

endinterface

// File: rtl/logos_cmd_fifo.sv
// Synchronous command FIFO; push is ignored when full and pop when empty.
module logos_cmd_fifo
    import logos_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  cmd_t                   wdata,
    output cmd_t                   rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/logos_multi_dispatch.sv
// In-order command dispatcher to NUM_ENG engines with per-engine context lanes,
// SYNC barrier and HALT drain.
module logos_multi_dispatch
    import logos_pkg::*;
#(
    parameter int NUM_ENG    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int N_CTX      = 4,
    parameter int SLOT_W     = CMD_SLOT_W,
    parameter int ADDR_W     = CMD_ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst,
    logos_multi_dispatch_if.slave        bus
);
    localparam int ENG_W = $clog2(NUM_ENG);

    disp_state_e        state_q, state_d;
    logic               halt_acc_q, halt_acc_d;
    logic [NUM_ENG-1:0] issue_q, issue_d;
    ctx_t               ctx_tbl_q [N_CTX];
    ctx_t               ctx_tbl_d [N_CTX];

    cmd_t               in_cmd, head;
    ctx_t               head_ctx;
    logic [ENG_W-1:0]   head_eng;
    logic               push, pop, full, empty;

    assign in_cmd   = '{opcode: bus.in_opcode, slot: bus.in_slot,
                        dma_addr: bus.in_dma_addr, ctx: bus.in_ctx};
    assign head_eng = head.slot[ENG_W-1:0];
    assign head_ctx = ctx_tbl_q[head.ctx];

    assign bus.in_ready = !rst && (state_q == ST_RUN) && !full && !halt_acc_q;
    assign push         = bus.in_valid && bus.in_ready;

    logos_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_cmd),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (bus.dbg_fifo_count)
    );

    always_comb begin
        state_d    = state_q;
        halt_acc_d = halt_acc_q || (push && bus.in_opcode == OP_HALT);
        issue_d    = '0;
        pop        = 1'b0;
        ctx_tbl_d  = ctx_tbl_q;
        if (bus.ctx_we) begin
            ctx_tbl_d[bus.ctx_waddr] = '{q: bus.ctx_wq, mu: bus.ctx_wmu, n_inv: bus.ctx_wninv};
        end
        unique case (state_q)
            ST_RUN: begin
                if (!empty) begin
                    if (head.opcode == OP_SYNC) begin
                        pop     = 1'b1;
                        state_d = ST_BARRIER;
                    end else if (head.opcode == OP_HALT) begin
                        pop     = 1'b1;
                        state_d = ST_DRAIN;
                    end else if (bus.eng_ready[head_eng] && !issue_q[head_eng]) begin
                        // An engine issued last cycle is skipped for one cycle.
                        pop               = 1'b1;
                        issue_d[head_eng] = 1'b1;
                    end
                end
            end
            ST_BARRIER: if (&bus.eng_ready && issue_q == '0) state_d = ST_RUN;
            ST_DRAIN:   if (&bus.eng_ready) state_d = ST_HALTED;
            default:    state_d = ST_HALTED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            halt_acc_q <= 1'b0;
            issue_q    <= '0;
            for (int i = 0; i < N_CTX; i++) ctx_tbl_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            halt_acc_q <= halt_acc_d;
            issue_q    <= issue_d;
            ctx_tbl_q  <= ctx_tbl_d;
        end
    end

    assign bus.eng_cmd_valid = issue_q;
    assign bus.halted        = (state_q == ST_HALTED);
    assign bus.dbg_state     = state_q;

    for (genvar e = 0; e < NUM_ENG; e++) begin : g_lane
        cmd_t cmd_q, cmd_d;
        ctx_t ctx_q, ctx_d;

        always_comb begin
            cmd_d = issue_d[e] ? head     : cmd_q;
            ctx_d = issue_d[e] ? head_ctx : ctx_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cmd_q <= '0;
                ctx_q <= '0;
            end else begin
                cmd_q <= cmd_d;
                ctx_q <= ctx_d;
            end
        end

        assign bus.eng_cmd_opcode[8*e +: 8]              = cmd_q.opcode;
        assign bus.eng_cmd_slot[SLOT_W*e +: SLOT_W]      = cmd_q.slot;
        assign bus.eng_cmd_dma_addr[ADDR_W*e +: ADDR_W]  = cmd_q.dma_addr;
        assign bus.eng_q[64*e +: 64]                     = ctx_q.q;
        assign bus.eng_mu[64*e +: 64]                    = ctx_q.mu;
        assign bus.eng_n_inv[64*e +: 64]                 = ctx_q.n_inv;
    end

endmodule

// File: tb/tb_logos_multi_dispatch.sv
// Scoreboard bench: stimulus pushes expected issues, a negedge monitor pops and compares.
module tb_logos_multi_dispatch;
    import logos_pkg::*;

    localparam int NUM_ENG    = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int N_CTX      = 4;
    localparam int SLOT_W     = 4;
    localparam int ADDR_W     = 48;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logos_multi_dispatch_if #(.NUM_ENG(NUM_ENG), .FIFO_DEPTH(FIFO_DEPTH), .N_CTX(N_CTX),
                              .SLOT_W(SLOT_W), .ADDR_W(ADDR_W)) bus ();

    logos_multi_dispatch #(.NUM_ENG(NUM_ENG), .FIFO_DEPTH(FIFO_DEPTH), .N_CTX(N_CTX),
                           .SLOT_W(SLOT_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          eng;
        logic [7:0]  op;
        logic [3:0]  slot;
        logic [47:0] addr;
        int          ctx;
    } exp_t;

    exp_t sb[$];
    ctx_t tbl_now  [N_CTX];
    ctx_t tbl_prev [N_CTX];
    logic [NUM_ENG-1:0] rdy_prev;
    logic [NUM_ENG-1:0] vld_prev;

    // Reference context table: a dispatch decided before an edge sees the table before that edge's write.
    always @(posedge clk) begin
        tbl_prev = tbl_now;
        if (rst) begin
            for (int i = 0; i < N_CTX; i++) tbl_now[i] = '0;
        end else if (bus.ctx_we) begin
            tbl_now[bus.ctx_waddr] = '{q: bus.ctx_wq, mu: bus.ctx_wmu, n_inv: bus.ctx_wninv};
        end
        rdy_prev = bus.eng_ready;
    end

    logic [NUM_ENG-1:0] mon_v;
    int                 mon_e;
    exp_t               mon_x;

    always @(negedge clk) begin
        if (rst) begin
            vld_prev = '0;
        end else begin
            mon_v = bus.eng_cmd_valid;
            if (mon_v != '0) begin
                mon_e = 0;
                for (int i = 0; i < NUM_ENG; i++) if (mon_v[i]) mon_e = i;
                check("issue_onehot", 64'($onehot(mon_v)), 64'd1);
                check("issue_guard", 64'(mon_v & vld_prev), 64'd0);
                check("issue_eng_was_ready", 64'(rdy_prev[mon_e]), 64'd1);
                check("issue_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    mon_x = sb.pop_front();
                    check("issue_engine", 64'(mon_e), 64'(mon_x.eng));
                    check("lane_opcode", 64'(bus.eng_cmd_opcode[8*mon_e +: 8]), 64'(mon_x.op));
                    check("lane_slot", 64'(bus.eng_cmd_slot[SLOT_W*mon_e +: SLOT_W]), 64'(mon_x.slot));
                    check("lane_addr", 64'(bus.eng_cmd_dma_addr[ADDR_W*mon_e +: ADDR_W]), 64'(mon_x.addr));
                    check("lane_q", bus.eng_q[64*mon_e +: 64], tbl_prev[mon_x.ctx].q);
                    check("lane_mu", bus.eng_mu[64*mon_e +: 64], tbl_prev[mon_x.ctx].mu);
                    check("lane_ninv", bus.eng_n_inv[64*mon_e +: 64], tbl_prev[mon_x.ctx].n_inv);
                end
            end
            vld_prev = mon_v;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [7:0] op, input logic [3:0] slot,
                           input logic [47:0] addr, input logic [1:0] ctx);
        bus.in_opcode   = op;
        bus.in_slot     = slot;
        bus.in_dma_addr = addr;
        bus.in_ctx      = ctx;
        bus.in_valid    = 1'b1;
    endtask

    task automatic note_accept();
        if (bus.in_opcode != OP_SYNC && bus.in_opcode != OP_HALT)
            sb.push_back('{eng: int'(bus.in_slot) % NUM_ENG, op: bus.in_opcode, slot: bus.in_slot,
                           addr: bus.in_dma_addr, ctx: int'(bus.in_ctx)});
    endtask

    task automatic offer(input logic [7:0] op, input logic [3:0] slot,
                         input logic [47:0] addr, input logic [1:0] ctx);
        bit acc = 1'b0;
        set_cmd(op, slot, addr, ctx);
        for (int i = 0; i < 200 && !acc; i++) begin
            if (bus.in_ready) begin
                note_accept();
                acc = 1'b1;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        check("offer_accepted", 64'(acc), 64'd1);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (bus.dbg_fifo_count == '0 && sb.size() == 0 && bus.eng_cmd_valid == '0) done = 1'b1;
        end
        check("drain_done", 64'(done), 64'd1);
        tick();
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.ctx_we   = 1'b0;
        bus.eng_ready = '1;
        sb.delete();
        repeat (2) tick();
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_rst_state", 64'(bus.dbg_state), 64'd0);
        check("post_rst_count", 64'(bus.dbg_fifo_count), 64'd0);
        check("post_rst_halted", 64'(bus.halted), 64'd0);
        check("post_rst_valid", 64'(bus.eng_cmd_valid), 64'd0);
        for (int e = 0; e < NUM_ENG; e++) begin
            check("post_rst_lane_op", 64'(bus.eng_cmd_opcode[8*e +: 8]), 64'd0);
            check("post_rst_lane_q", bus.eng_q[64*e +: 64], 64'd0);
        end
        tick();
    endtask

    function automatic logic [47:0] rnd_addr();
        logic [63:0] t = {$urandom(), $urandom()};
        return t[47:0];
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0]  b2b_exp [7] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
        logic [3:0]  hol_exp [6] = '{4'h0, 4'h2, 4'h0, 4'h2, 4'h4, 4'h0};
        logic [3:0]  syn_vld [3] = '{4'h0, 4'h0, 4'h2};
        logic [1:0]  syn_st  [3] = '{2'd1, 2'd0, 2'd0};
        logic [63:0] q_new = 64'hFFFF_FFFF_0000_0001;
        bit          seen;

        bus.in_valid = 0; bus.in_opcode = 0; bus.in_slot = 0; bus.in_dma_addr = 0; bus.in_ctx = 0;
        bus.ctx_we = 0; bus.ctx_waddr = 0; bus.ctx_wq = 0; bus.ctx_wmu = 0; bus.ctx_wninv = 0;
        bus.eng_ready = '1;
        do_reset();

        // Back-to-back commands to engines 0..3.
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                set_cmd(8'h20 + 8'(i), 4'(i), rnd_addr(), 2'd0);
                check("b2b_in_ready", 64'(bus.in_ready), 64'd1);
                note_accept();
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            check("b2b_valid", 64'(bus.eng_cmd_valid), 64'(b2b_exp[i]));
            tick();
        end
        wait_idle();

        // Engine 1 busy: head-of-line blocking, then guard between two engine-1 issues.
        bus.eng_ready = 4'b1101;
        offer(8'h31, 4'd1, rnd_addr(), 2'd1);
        offer(8'h32, 4'd5, rnd_addr(), 2'd0);
        offer(8'h33, 4'd2, rnd_addr(), 2'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hol_blocked", 64'(bus.eng_cmd_valid), 64'd0);
            tick();
        end
        bus.eng_ready = '1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("hol_release", 64'(bus.eng_cmd_valid), 64'(hol_exp[i]));
            tick();
        end
        wait_idle();

        // Context write in the same cycle as a dispatch that reads it.
        set_cmd(8'h40, 4'd3, rnd_addr(), 2'd2);
        check("ctx_in_ready", 64'(bus.in_ready), 64'd1);
        note_accept();
        tick();
        bus.in_valid  = 1'b0;
        bus.ctx_we    = 1'b1;
        bus.ctx_waddr = 2'd2;
        bus.ctx_wq    = q_new;
        bus.ctx_wmu   = {$urandom(), $urandom()};
        bus.ctx_wninv = {$urandom(), $urandom()};
        tick();
        bus.ctx_we = 1'b0;
        @(negedge clk);
        check("ctx_same_cycle_valid", 64'(bus.eng_cmd_valid), 64'h8);
        check("ctx_same_cycle_old_q", bus.eng_q[64*3 +: 64], 64'd0);
        tick();
        offer(8'h41, 4'd0, rnd_addr(), 2'd2);
        wait_idle();
        check("ctx_next_new_q", bus.eng_q[0 +: 64], q_new);

        // Fill the FIFO behind a busy engine 0.
        bus.eng_ready = 4'b1110;
        for (int i = 0; i < FIFO_DEPTH; i++) offer(8'h50 + 8'(i), 4'(4 * (i % 4)), rnd_addr(), 2'(i));
        @(negedge clk);
        check("full_count", 64'(bus.dbg_fifo_count), 64'd8);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        set_cmd(8'h5F, 4'd1, rnd_addr(), 2'd0);
        repeat (3) tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("full_ninth_rejected", 64'(bus.dbg_fifo_count), 64'd8);
        tick();
        bus.eng_ready = '1;
        wait_idle();

        // SYNC barrier held open by a busy engine 2.
        bus.eng_ready = 4'b1011;
        offer(8'h60, 4'd0, rnd_addr(), 2'd0);
        offer(OP_SYNC, 4'd0, rnd_addr(), 2'd0);
        offer(8'h61, 4'd1, rnd_addr(), 2'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("sync_state_barrier", 64'(bus.dbg_state), 64'd1);
            check("sync_no_issue", 64'(bus.eng_cmd_valid), 64'd0);
            if (i == 0) check("sync_in_ready", 64'(bus.in_ready), 64'd0);
            tick();
        end
        bus.eng_ready = '1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sync_exit_state", 64'(bus.dbg_state), 64'(syn_st[i]));
            check("sync_exit_valid", 64'(bus.eng_cmd_valid), 64'(syn_vld[i]));
            tick();
        end
        wait_idle();

        // Randomized traffic with SYNCs, context writes and random engine readiness.
        for (int c = 0; c < 800; c++) begin
            for (int e = 0; e < NUM_ENG; e++) bus.eng_ready[e] = ($urandom_range(0, 9) < 8);
            bus.ctx_we    = ($urandom_range(0, 5) == 0);
            bus.ctx_waddr = 2'($urandom_range(0, N_CTX - 1));
            bus.ctx_wq    = {$urandom(), $urandom()};
            bus.ctx_wmu   = {$urandom(), $urandom()};
            bus.ctx_wninv = {$urandom(), $urandom()};
            if (!bus.in_valid && $urandom_range(0, 3) != 0)
                set_cmd(($urandom_range(0, 15) == 0) ? OP_SYNC : 8'($urandom_range(0, 253)),
                        4'($urandom_range(0, 15)), rnd_addr(), 2'($urandom_range(0, N_CTX - 1)));
            seen = bus.in_valid && bus.in_ready;
            if (seen) note_accept();
            tick();
            if (seen) bus.in_valid = 1'b0;
        end
        bus.in_valid  = 1'b0;
        bus.ctx_we    = 1'b0;
        bus.eng_ready = '1;
        wait_idle();

        // HALT after two commands, drained once every engine is ready.
        bus.eng_ready = 4'b0111;
        offer(8'h71, 4'd1, rnd_addr(), 2'd0);
        offer(8'h72, 4'd2, rnd_addr(), 2'd1);
        offer(OP_HALT, 4'd0, rnd_addr(), 2'd0);
        @(negedge clk);
        check("halt_in_ready_drop", 64'(bus.in_ready), 64'd0);
        tick();
        tick();
        @(negedge clk);
        check("halt_drain_state", 64'(bus.dbg_state), 64'd2);
        check("halt_drain_not_halted", 64'(bus.halted), 64'd0);
        tick();
        bus.eng_ready = '1;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            seen = bus.halted;
        end
        check("halted_set", 64'(seen), 64'd1);
        check("halted_state", 64'(bus.dbg_state), 64'd3);
        check("halted_sb_empty", 64'(sb.size()), 64'd0);
        tick();
        set_cmd(8'h73, 4'd0, rnd_addr(), 2'd0);
        repeat (3) tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("halted_no_accept", 64'(bus.dbg_fifo_count), 64'd0);
        check("halted_sticky", 64'(bus.halted), 64'd1);
        tick();
        do_reset();

        // Reset in the middle of a HALT drain.
        bus.eng_ready = 4'b0111;
        offer(8'h81, 4'd0, rnd_addr(), 2'd0);
        offer(OP_HALT, 4'd0, rnd_addr(), 2'd0);
        repeat (3) tick();
        @(negedge clk);
        check("drain2_state", 64'(bus.dbg_state), 64'd2);
        check("drain2_lane0_op", 64'(bus.eng_cmd_opcode[0 +: 8]), 64'h81);
        tick();
        do_reset();
        offer(8'h90, 4'd2, rnd_addr(), 2'd0);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
